// File: rtl/fft_pkg.sv
// Shared helpers for the pipelined FFT blocks: log2 of a depth, {re, im} packing
// positions, and the power-of-two legality check for commutator depths.
package fft_pkg;

  function automatic int log2_delay(input int d);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < d) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit delay_is_pow2(input int d);
    return (d >= 1) && ((d & (d - 1)) == 0);
  endfunction

  // A sample word is {re, im}; re occupies the upper W bits.
  function automatic int re_msb(input int w);
    return 2 * w - 1;
  endfunction

  function automatic int im_msb(input int w);
    return w - 1;
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Circular-buffer delay of DEPTH enabled samples; read precedes write at the same
// slot, so rd_data_o is the word written DEPTH enables ago.
module fft_delay_line
  import fft_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 44
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] rd_data_o
);

  if (DEPTH == 1) begin : g_single
    logic [WIDTH-1:0] data_q;
    logic             unused_rst;

    // A single register needs no pointer, so reset has nothing to clear.
    assign unused_rst = rst_i;

    always_ff @(posedge clk_i) begin
      if (en_i) data_q <= wr_data_i;
    end

    assign rd_data_o = data_q;
  end else begin : g_ring
    localparam int PW = log2_delay(DEPTH);

    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign ptr_d     = ptr_q + PW'(1);
    assign rd_data_o = mem_q[ptr_q];

    always_ff @(posedge clk_i) begin
      if (rst_i)     ptr_q <= '0;
      else if (en_i) ptr_q <= ptr_d;
    end

    // Storage is deliberately not reset; the fill period overwrites every slot.
    always_ff @(posedge clk_i) begin
      if (en_i) mem_q[ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/fft_commutator.sv
// Two-lane delay-and-swap commutator for a 2-parallel pipelined FFT stage.
// Optional macro FFT_COMMUTATOR_SOF_EN adds out_sof marking the first pair of each block.
module fft_commutator
  import fft_pkg::*;
#(
  parameter int NBITS = 10,
  parameter int W     = 2 * (NBITS + 1),
  parameter int DELAY = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2*W-1:0] in_up,
  input  logic [2*W-1:0] in_down,
  input  logic           in_valid,
  output logic [2*W-1:0] out_up,
  output logic [2*W-1:0] out_down,
  output logic           out_valid
`ifdef FFT_COMMUTATOR_SOF_EN
  ,
  output logic           out_sof
`endif
);

  localparam int LOG2D = log2_delay(DELAY);
  localparam int CW    = LOG2D + 1;

  if (!delay_is_pow2(DELAY)) begin : g_bad_delay
    $error("fft_commutator: DELAY must be a power of two and at least 1");
  end

  logic [CW-1:0]  cnt_q, cnt_d;
  logic           filled_q, filled_d;
  logic [2*W-1:0] out_up_q, out_down_q;
  logic           out_valid_q;
  logic [2*W-1:0] dly_a, dly_b;
  logic [2*W-1:0] x_lane, y_lane;
  logic           sel;

  assign sel = cnt_q[LOG2D];

  always_comb begin
    cnt_d    = cnt_q;
    filled_d = filled_q;
    if (in_valid) begin
      cnt_d    = cnt_q + CW'(1);
      filled_d = filled_q | (cnt_q == '1);
    end
  end

  // In the second half of each 2*DELAY window the lanes cross over.
  always_comb begin
    x_lane = dly_a;
    y_lane = in_down;
    if (sel) begin
      x_lane = in_down;
      y_lane = dly_a;
    end
  end

  fft_delay_line #(
    .DEPTH (DELAY),
    .WIDTH (2 * W)
  ) u_line_a (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (in_valid),
    .wr_data_i (in_up),
    .rd_data_o (dly_a)
  );

  fft_delay_line #(
    .DEPTH (DELAY),
    .WIDTH (2 * W)
  ) u_line_b (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (in_valid),
    .wr_data_i (y_lane),
    .rd_data_o (dly_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      filled_q    <= 1'b0;
      out_up_q    <= '0;
      out_down_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      filled_q    <= filled_d;
      out_valid_q <= in_valid && filled_q;
      if (in_valid) begin
        out_up_q   <= x_lane;
        out_down_q <= dly_b;
      end
    end
  end

  assign out_up    = out_up_q;
  assign out_down  = out_down_q;
  assign out_valid = out_valid_q;

`ifdef FFT_COMMUTATOR_SOF_EN
  logic sof_q;

  always_ff @(posedge clk) begin
    if (rst) sof_q <= 1'b0;
    else     sof_q <= in_valid && filled_q && (cnt_q == '0);
  end

  assign out_sof = sof_q;
`endif

endmodule

// File: tb/tb_fft_commutator.sv
// Bench for fft_commutator: DELAY=2 fill/stall/reset table, DELAY=1 sign/width, DELAY=8 random.
// Define FFT_COMMUTATOR_SOF_EN to also check out_sof.
module tb_fft_commutator;
  import fft_pkg::*;

  localparam int W  = 22;
  localparam int LW = 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [LW-1:0] in_up;
  logic [LW-1:0] in_down;
  logic [LW-1:0] o_up [3];
  logic [LW-1:0] o_dn [3];
  logic          o_v  [3];
`ifdef FFT_COMMUTATOR_SOF_EN
  logic          o_sof [3];
`endif

  always #5 clk = ~clk;

  fft_commutator #(.NBITS(10), .W(W), .DELAY(2)) u_d2 (
    .clk(clk), .rst(rst), .in_up(in_up), .in_down(in_down), .in_valid(in_valid),
    .out_up(o_up[0]), .out_down(o_dn[0]), .out_valid(o_v[0])
`ifdef FFT_COMMUTATOR_SOF_EN
    , .out_sof(o_sof[0])
`endif
  );

  fft_commutator #(.NBITS(10), .W(W), .DELAY(1)) u_d1 (
    .clk(clk), .rst(rst), .in_up(in_up), .in_down(in_down), .in_valid(in_valid),
    .out_up(o_up[1]), .out_down(o_dn[1]), .out_valid(o_v[1])
`ifdef FFT_COMMUTATOR_SOF_EN
    , .out_sof(o_sof[1])
`endif
  );

  fft_commutator #(.NBITS(10), .W(W), .DELAY(8)) u_d8 (
    .clk(clk), .rst(rst), .in_up(in_up), .in_down(in_down), .in_valid(in_valid),
    .out_up(o_up[2]), .out_down(o_dn[2]), .out_valid(o_v[2])
`ifdef FFT_COMMUTATOR_SOF_EN
    , .out_sof(o_sof[2])
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference state: history of accepted samples since reset for the targeted instance.
  int            tgt;
  int            td;
  int            n_acc;
  logic [LW-1:0] hu[$];
  logic [LW-1:0] hd[$];
  logic [LW-1:0] exp_up, exp_dn;
  logic          exp_v, exp_sof;
  bit            exp_known;

  function automatic logic [LW-1:0] pk(input int re, input int im);
    logic [LW-1:0] r;
    r = '0;
    r[re_msb(W):im_msb(W)+1] = W'(re);
    r[im_msb(W):0]           = W'(im);
    return r;
  endfunction

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Expected pair from the defining equations: lane A = in_up history, lane B = in_down history.
  task automatic step(input logic r, input logic v, input logic [LW-1:0] u, input logic [LW-1:0] d);
    int n;
    @(negedge clk);
    rst = r; in_valid = v; in_up = u; in_down = d;
    @(posedge clk);
    #1;
    if (r) begin
      hu.delete(); hd.delete();
      n_acc = 0; exp_up = '0; exp_dn = '0; exp_known = 1'b1; exp_v = 1'b0; exp_sof = 1'b0;
    end else if (v) begin
      hu.push_back(u); hd.push_back(d);
      n = n_acc; n_acc++;
      if (n >= 2 * td) begin
        if (((n / td) % 2) == 0) begin
          exp_up = hu[n - td]; exp_dn = hu[n - 2 * td];
        end else begin
          exp_up = hd[n];      exp_dn = hd[n - td];
        end
        exp_known = 1'b1; exp_v = 1'b1; exp_sof = ((n % (2 * td)) == 0);
      end else begin
        exp_known = 1'b0; exp_v = 1'b0; exp_sof = 1'b0;
      end
    end else begin
      exp_v = 1'b0; exp_sof = 1'b0;
    end
    check("model_valid", LW'(o_v[tgt]), LW'(exp_v));
    if (exp_known) begin
      check("model_up", o_up[tgt], exp_up);
      check("model_down", o_dn[tgt], exp_dn);
    end
`ifdef FFT_COMMUTATOR_SOF_EN
    check("model_sof", LW'(o_sof[tgt]), LW'(exp_sof));
`endif
  endtask

  typedef struct {
    logic v;
    int   up_re;
    int   dn_re;
    logic ev;
    int   eu;
    int   ed;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [LW-1:0] p_up, p_dn;
    int acc;
    rst = 1'b1; in_valid = 1'b0; in_up = '0; in_down = '0;

    // Fill, pairing and stall, DELAY=2.
    tbl[0]  = '{1'b1, 1, 101, 1'b0, -1, -1};
    tbl[1]  = '{1'b1, 2, 102, 1'b0, -1, -1};
    tbl[2]  = '{1'b1, 3, 103, 1'b0, -1, -1};
    tbl[3]  = '{1'b1, 4, 104, 1'b0, -1, -1};
    tbl[4]  = '{1'b1, 5, 105, 1'b1, 3, 1};
    tbl[5]  = '{1'b1, 6, 106, 1'b1, 4, 2};
    tbl[6]  = '{1'b0, 0, 0,   1'b0, 4, 2};
    tbl[7]  = '{1'b0, 0, 0,   1'b0, 4, 2};
    tbl[8]  = '{1'b0, 0, 0,   1'b0, 4, 2};
    tbl[9]  = '{1'b1, 7, 107, 1'b1, 107, 105};
    tbl[10] = '{1'b1, 8, 108, 1'b1, 108, 106};
    tbl[11] = '{1'b1, 9, 109, 1'b1, 7, 5};
    tbl[12] = '{1'b1, 10, 110, 1'b1, 8, 6};

    tgt = 0; td = 2;
    step(1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      check("reset_up", o_up[i], '0);
      check("reset_down", o_dn[i], '0);
      check("reset_valid", LW'(o_v[i]), '0);
    end
    for (int i = 0; i < 13; i++) begin
      step(1'b0, tbl[i].v, pk(tbl[i].up_re, 0), pk(tbl[i].dn_re, 0));
      check("tbl_valid", LW'(o_v[0]), LW'(tbl[i].ev));
      if (tbl[i].eu >= 0) begin
        check("tbl_up", o_up[0], pk(tbl[i].eu, 0));
        check("tbl_down", o_dn[0], pk(tbl[i].ed, 0));
      end
    end

    // Reset mid-stream with in_valid high, DELAY=2.
    step(1'b1, 1'b0, '0, '0);
    for (int i = 1; i <= 9; i++) step(1'b0, 1'b1, pk(i, 0), pk(100 + i, 0));
    step(1'b1, 1'b1, pk(99, 0), pk(199, 0));
    check("midrst_up", o_up[0], '0);
    check("midrst_down", o_dn[0], '0);
    check("midrst_valid", LW'(o_v[0]), '0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, pk(201 + i, 0), pk(301 + i, 0));
      if (i < 4) check("restart_fill_valid", LW'(o_v[0]), '0);
      if (i == 4) begin
        check("restart_valid", LW'(o_v[0]), LW'(1'b1));
        check("restart_up", o_up[0], pk(203, 0));
        check("restart_down", o_dn[0], pk(201, 0));
      end
    end

    // Sign and width extremes, DELAY=1.
    tgt = 1; td = 1;
    p_up = pk(-1, 5);
    p_dn = pk(-(1 << (W - 1)), (1 << (W - 1)) - 1);
    step(1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) step(1'b0, 1'b1, p_up, p_dn);
      else            step(1'b0, 1'b1, ~p_up, ~p_dn);
      if (i == 2) check("sign_up_a", o_up[1], ~p_up);
      if (i == 2) check("sign_down_a", o_dn[1], p_up);
      if (i == 3) check("sign_up_b", o_up[1], ~p_dn);
      if (i == 3) check("sign_down_b", o_dn[1], p_dn);
    end

    // Random data and gaps, DELAY=8, across many counter wraps.
    tgt = 2; td = 8;
    step(1'b1, 1'b0, '0, '0);
    acc = 0;
    while (acc < 1000) begin
      if ($urandom_range(0, 3) != 0) begin
        step(1'b0, 1'b1, LW'({$urandom(), $urandom()}), LW'({$urandom(), $urandom()}));
        acc++;
      end else begin
        step(1'b0, 1'b0, LW'({$urandom(), $urandom()}), LW'({$urandom(), $urandom()}));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
